// File: rtl/sys_clk_divider_bank.sv
// rtl/sys_clk_divider_bank.sv - reconfigurable bank of divided, phase-offset clocks with lock indicator
module sys_clk_divider_bank #(
  parameter int NUM_CLOCKS    = 2,
  parameter int DIV_WIDTH     = 16,
  parameter int LOCK_CYCLES   = 16,
  parameter int DEFAULT_DIV   = 2,
  parameter int DEFAULT_PHASE = 0,
  parameter int SEL_WIDTH     = 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [SEL_WIDTH-1:0]  cfg_sel,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [DIV_WIDTH-1:0]  cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int SW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES);
  localparam logic [SW-1:0] L_SETTLE_LAST = SW'(LOCK_CYCLES - 1);
  localparam logic [DIV_WIDTH-1:0] L_DEF_DIV =
    (DEFAULT_DIV == 0) ? DIV_WIDTH'(1) : DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] L_DEF_PHASE =
    (DIV_WIDTH'(DEFAULT_PHASE) >= L_DEF_DIV) ? '0 : DIV_WIDTH'(DEFAULT_PHASE);
  localparam logic [SEL_WIDTH:0] L_NUM = (SEL_WIDTH + 1)'(NUM_CLOCKS);

  typedef enum logic {S_SETTLE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SW-1:0]        r_settle_cnt;
  logic [SW-1:0]        w_settle_nxt;

  logic [DIV_WIDTH-1:0] r_div   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] r_phase [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] r_cnt   [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] w_cnt_nxt [NUM_CLOCKS];
  logic [DIV_WIDTH-1:0] w_half    [NUM_CLOCKS];

  logic [NUM_CLOCKS-1:0] r_outclk;
  logic [NUM_CLOCKS-1:0] r_outclk_en;
  logic [NUM_CLOCKS-1:0] w_outclk_nxt;
  logic [NUM_CLOCKS-1:0] w_outclk_en_nxt;

  logic                 w_accept;
  logic                 w_cfg_hit;
  logic [DIV_WIDTH-1:0] w_cfg_div;
  logic [DIV_WIDTH-1:0] w_cfg_phase;

  assign locked    = (r_state == S_LOCKED);
  assign cfg_ready = (r_state == S_LOCKED);
  assign outclk    = r_outclk;
  assign outclk_en = r_outclk_en;

  // Out-of-range selects complete the handshake but touch nothing.
  assign w_accept    = cfg_valid && cfg_ready;
  assign w_cfg_hit   = w_accept && ({1'b0, cfg_sel} < L_NUM);
  assign w_cfg_div   = (cfg_div == '0) ? DIV_WIDTH'(1) : cfg_div;
  assign w_cfg_phase = (cfg_phase >= w_cfg_div) ? '0 : cfg_phase;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= S_SETTLE;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle_cnt;
    case (r_state)
      S_SETTLE: begin
        if (r_settle_cnt == L_SETTLE_LAST) begin
          w_state_nxt  = S_LOCKED;
          w_settle_nxt = '0;
        end else begin
          w_settle_nxt = r_settle_cnt + SW'(1);
        end
      end
      S_LOCKED: begin
        if (w_cfg_hit) begin
          w_state_nxt  = S_SETTLE;
          w_settle_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_SETTLE;
        w_settle_nxt = '0;
      end
    endcase
  end

  // Counters only run while locked and stay there; any other path parks them at phase.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      w_half[i] = r_div[i] - (r_div[i] >> 1);
      if (w_cfg_hit && (cfg_sel == SEL_WIDTH'(i))) begin
        w_cnt_nxt[i] = w_cfg_phase;
      end else if ((r_state == S_LOCKED) && !w_cfg_hit) begin
        w_cnt_nxt[i] = (r_cnt[i] == r_div[i] - DIV_WIDTH'(1)) ? '0 : r_cnt[i] + DIV_WIDTH'(1);
      end else begin
        w_cnt_nxt[i] = r_phase[i];
      end
      w_outclk_nxt[i]    = (w_state_nxt == S_LOCKED) && (w_cnt_nxt[i] < w_half[i]);
      w_outclk_en_nxt[i] = (w_state_nxt == S_LOCKED) &&
                           (w_cnt_nxt[i] == r_div[i] - DIV_WIDTH'(1));
    end
  end

  always_ff @(posedge refclk) begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      if (rst) begin
        r_div[i]   <= L_DEF_DIV;
        r_phase[i] <= L_DEF_PHASE;
        r_cnt[i]   <= L_DEF_PHASE;
      end else begin
        if (w_cfg_hit && (cfg_sel == SEL_WIDTH'(i))) begin
          r_div[i]   <= w_cfg_div;
          r_phase[i] <= w_cfg_phase;
        end
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_outclk    <= '0;
      r_outclk_en <= '0;
    end else begin
      r_outclk    <= w_outclk_nxt;
      r_outclk_en <= w_outclk_en_nxt;
    end
  end

endmodule

// File: tb/tb_sys_clk_divider_bank.sv
// tb/tb_sys_clk_divider_bank.sv - scoreboard bench for sys_clk_divider_bank
module tb_sys_clk_divider_bank;

  logic        refclk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_div;
  logic [15:0] cfg_phase;
  logic [1:0]  outclk;
  logic [1:0]  outclk_en;
  logic        locked;

  sys_clk_divider_bank #(
    .NUM_CLOCKS(2), .DIV_WIDTH(16), .LOCK_CYCLES(16),
    .DEFAULT_DIV(2), .DEFAULT_PHASE(0), .SEL_WIDTH(2)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  always #5 refclk = ~refclk;

  int checks = 0;
  int failures = 0;
  string tag = "init";
  logic [5:0] sb [$];

  int m_div [2];
  int m_phase [2];
  bit m_lock;
  int m_settle;
  int m_t;
  bit m_acc;

  task automatic model(input bit r, input bit v, input int s, input int d, input int p,
                       output logic [5:0] e);
    int c;
    int dd;
    logic [1:0] oc;
    logic [1:0] en;
    m_acc = 0;
    if (r) begin
      for (int i = 0; i < 2; i++) begin
        m_div[i] = 2;
        m_phase[i] = 0;
      end
      m_lock = 0;
      m_settle = 0;
    end else if (m_lock) begin
      if (v) begin
        m_acc = 1;
        if (s < 2) begin
          dd = (d == 0) ? 1 : d;
          m_div[s] = dd;
          m_phase[s] = (p >= dd) ? 0 : p;
          m_lock = 0;
          m_settle = 0;
        end else begin
          m_t++;
        end
      end else begin
        m_t++;
      end
    end else begin
      m_settle++;
      if (m_settle == 16) begin
        m_lock = 1;
        m_t = 0;
      end
    end
    oc = '0;
    en = '0;
    if (m_lock) begin
      for (int i = 0; i < 2; i++) begin
        c = (m_phase[i] + m_t) % m_div[i];
        oc[i] = (c < (m_div[i] + 1) / 2);
        en[i] = (c == m_div[i] - 1);
      end
    end
    e = {m_lock, m_lock, oc, en};
  endtask

  task automatic cyc(input bit r, input bit v, input int s, input int d, input int p);
    logic [5:0] e;
    logic [5:0] o;
    @(negedge refclk);
    rst = r;
    cfg_valid = v;
    cfg_sel = s[1:0];
    cfg_div = d[15:0];
    cfg_phase = p[15:0];
    model(r, v, s, d, p, e);
    sb.push_back(e);
    @(posedge refclk);
    #1;
    o = {locked, cfg_ready, outclk, outclk_en};
    e = sb.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%b exp=%b", tag, o, e);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic write_cfg(input int s, input int d, input int p);
    cyc(0, 1, s, d, p);
    checks++;
    assert (m_acc) else begin
      failures++;
      $error("FAIL %s_accept obs=%0d exp=1", tag, m_acc);
    end
  endtask

  initial begin
    int lat;
    int k;
    refclk = 0;
    rst = 1;
    cfg_valid = 0;
    cfg_sel = 0;
    cfg_div = 0;
    cfg_phase = 0;

    tag = "reset";
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 7, 0);

    tag = "lock_latency";
    lat = 0;
    while (!locked && lat < 40) begin
      cyc(0, 0, 0, 0, 0);
      lat++;
    end
    checks++;
    assert (lat == 16) else begin
      failures++;
      $error("FAIL lock_latency obs=%0d exp=16", lat);
    end
    tag = "default_run";
    idle(6);

    tag = "div5";
    write_cfg(0, 5, 0);
    idle(28);

    tag = "div4_ph0";
    write_cfg(0, 4, 0);
    tag = "hold_in_settle";
    k = 0;
    m_acc = 0;
    while (!m_acc && k < 40) begin
      cyc(0, 1, 1, 4, 2);
      k++;
    end
    checks++;
    assert (k == 17) else begin
      failures++;
      $error("FAIL hold_in_settle obs=%0d exp=17", k);
    end
    tag = "quadrature";
    idle(26);

    tag = "div0";
    write_cfg(0, 0, 0);
    idle(22);
    tag = "div3_ph7";
    write_cfg(1, 3, 7);
    idle(24);

    tag = "bad_sel";
    write_cfg(3, 9, 1);
    idle(5);

    tag = "rst_locked";
    cyc(1, 0, 0, 0, 0);
    idle(8);
    tag = "rst_settle";
    cyc(1, 0, 0, 0, 0);
    idle(22);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
